// File: rtl/phase_generator_pkg.sv
// Shared types and constants for the two-phase CPU clock generator.
package phase_pkg;

  // Width of the in-state cycle counter; wide enough for the longest phase.
  localparam int CNT_WIDTH = 8;

  // Phase sequencer states. HALT parks the CPU between cycles.
  typedef enum logic [2:0] {
    HALT,
    PHI1,
    GAP12,
    PHI2,
    GAP21
  } phase_state_e;

  // True when the phase timing fits the counter and the gap range.
  function automatic bit timing_params_ok(input int half_period, input int gap_cycles);
    return (half_period >= 1) && (half_period <= 255) &&
           (gap_cycles >= 0) && (gap_cycles <= 15);
  endfunction

endpackage

// File: rtl/phase_generator_if.sv
// Control inputs and clock/strobe outputs of the phase generator.
interface phase_generator_if #(
  parameter int COUNT_WIDTH = 16
) ();

  // Control from the debug/bus side
  logic                   enable;
  logic                   step;
  logic                   rdy;
  logic                   rw;

  // Phase clocks, edge strobes and status
  logic                   phi1;
  logic                   phi2;
  logic                   phase_1_rising;
  logic                   phase_1_falling;
  logic                   phase_2_rising;
  logic                   phase_2_falling;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] cycle_count;

  // Drives control and observes the clocks (testbench / debug controller)
  modport master (
    output enable, step, rdy, rw,
    input  phi1, phi2, phase_1_rising, phase_1_falling,
    input  phase_2_rising, phase_2_falling, halted, cycle_count
  );

  // The generator itself
  modport slave (
    input  enable, step, rdy, rw,
    output phi1, phi2, phase_1_rising, phase_1_falling,
    output phase_2_rising, phase_2_falling, halted, cycle_count
  );

endinterface

// File: rtl/phase_generator.sv
// Two-phase non-overlapping clock generator with RDY stall, run/halt and
// single-step. Every output is a register loaded from next-state decode, so
// the edge strobes line up exactly with the level changes of phi1/phi2.
module phase_generator
  import phase_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic             sys_clock,
  input  logic             reset,
  phase_generator_if.slave pg
);

  if (!timing_params_ok(HALF_PERIOD, GAP_CYCLES)) begin : g_bad_params
    $error("phase_generator: HALF_PERIOD must be 1..255 and GAP_CYCLES 0..15");
  end

  localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(HALF_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit                   HAS_GAP   = (GAP_CYCLES > 0);

  phase_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  // Set by reset: the first clock afterwards is treated as a fresh PHI1 entry.
  logic                   entry_pending_q, entry_pending_d;
  // A step pulse seen while a cycle is running, consumed at the cycle boundary.
  logic                   step_lat_q, step_lat_d;
  logic                   count_inc;
  logic                   boundary;

  logic                   phi1_q, phi1_d;
  logic                   phi2_q, phi2_d;
  logic                   p1_rise_q, p1_rise_d;
  logic                   p1_fall_q, p1_fall_d;
  logic                   p2_rise_q, p2_rise_d;
  logic                   p2_fall_q, p2_fall_d;
  logic                   halted_q, halted_d;
  logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;

  // Next-state decode: phase sequencing, RDY stall, cycle-boundary run/halt.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    entry_pending_d = 1'b0;
    step_lat_d      = step_lat_q;
    count_inc       = 1'b0;
    boundary        = 1'b0;

    if (state_q != HALT && pg.step) begin
      step_lat_d = 1'b1;
    end

    if (entry_pending_q) begin
      state_d = PHI1;
    end else begin
      unique case (state_q)
        HALT: begin
          if (pg.enable || pg.step) state_d = PHI1;
        end
        PHI1: begin
          if (cnt_q == HALF_LAST) begin
            // A read with RDY low holds phi1 high and freezes the count.
            if (!(pg.rw && !pg.rdy)) state_d = HAS_GAP ? GAP12 : PHI2;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP12: begin
          if (cnt_q == GAP_LAST) state_d = PHI2;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        PHI2: begin
          if (cnt_q == HALF_LAST) begin
            count_inc = 1'b1;
            if (HAS_GAP) state_d  = GAP21;
            else         boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP21: begin
          if (cnt_q == GAP_LAST) boundary = 1'b1;
          else                   cnt_d    = cnt_q + 1'b1;
        end
        default: state_d = HALT;
      endcase
    end

    if (boundary) begin
      state_d    = (pg.enable || step_lat_q || pg.step) ? PHI1 : HALT;
      step_lat_d = 1'b0;
    end

    if (state_d != state_q || entry_pending_q) begin
      cnt_d = '0;
    end
  end

  // Output decode from the next state; strobes compare against current levels.
  always_comb begin
    phi1_d        = (state_d == PHI1);
    phi2_d        = (state_d == PHI2);
    halted_d      = (state_d == HALT);
    p1_rise_d     =  phi1_d & ~phi1_q;
    p1_fall_d     = ~phi1_d &  phi1_q;
    p2_rise_d     =  phi2_d & ~phi2_q;
    p2_fall_d     = ~phi2_d &  phi2_q;
    cycle_count_d = cycle_count_q + COUNT_WIDTH'(count_inc);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge sys_clock) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q         <= PHI1;
      cnt_q           <= '0;
      entry_pending_q <= 1'b1;
      step_lat_q      <= 1'b0;
      phi1_q          <= 1'b0;
      phi2_q          <= 1'b0;
      p1_rise_q       <= 1'b0;
      p1_fall_q       <= 1'b0;
      p2_rise_q       <= 1'b0;
      p2_fall_q       <= 1'b0;
      halted_q        <= 1'b0;
      cycle_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      entry_pending_q <= entry_pending_d;
      step_lat_q      <= step_lat_d;
      phi1_q          <= phi1_d;
      phi2_q          <= phi2_d;
      p1_rise_q       <= p1_rise_d;
      p1_fall_q       <= p1_fall_d;
      p2_rise_q       <= p2_rise_d;
      p2_fall_q       <= p2_fall_d;
      halted_q        <= halted_d;
      cycle_count_q   <= cycle_count_d;
    end
  end

  assign pg.phi1            = phi1_q;
  assign pg.phi2            = phi2_q;
  assign pg.phase_1_rising  = p1_rise_q;
  assign pg.phase_1_falling = p1_fall_q;
  assign pg.phase_2_rising  = p2_rise_q;
  assign pg.phase_2_falling = p2_fall_q;
  assign pg.halted          = halted_q;
  assign pg.cycle_count     = cycle_count_q;

  // The two phases must never overlap.
  a_phases_exclusive: assert property (@(posedge sys_clock) !(phi1_q && phi2_q));

endmodule

// File: tb/tb_phase_generator.sv
// Scoreboard bench: expected outputs are queued, tagged with the clock edge
// they belong to, and compared on the following falling edge.
// DUT A runs the default timing; DUT B runs HALF_PERIOD=1, GAP_CYCLES=0 with
// an 8-bit counter so the wrap-around fits in a short run.
module tb_phase_generator;

  localparam int A_H   = 4;
  localparam int A_G   = 1;
  localparam int A_PER = 2 * (A_H + A_G);

  logic sys_clock = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 sys_clock = ~sys_clock;

  phase_generator_if #(.COUNT_WIDTH(16)) a_if ();
  phase_generator_if #(.COUNT_WIDTH(8))  b_if ();

  phase_generator #(.HALF_PERIOD(A_H), .GAP_CYCLES(A_G), .COUNT_WIDTH(16)) u_dut_a (
    .sys_clock (sys_clock),
    .reset     (reset_a),
    .pg        (a_if)
  );

  phase_generator #(.HALF_PERIOD(1), .GAP_CYCLES(0), .COUNT_WIDTH(8)) u_dut_b (
    .sys_clock (sys_clock),
    .reset     (reset_b),
    .pg        (b_if)
  );

  typedef struct {
    int          cyc;
    string       tag;
    bit          dut_b;
    bit          is_count;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_n  = 0;
  int   checks = 0;
  int   errors = 0;

  // Model state: position within the A period, A count, B edge index.
  int   a_pos;
  int   a_count;
  int   b_k;

  always @(posedge sys_clock) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit phi1, input bit phi2, input bit p1r,
                                     input bit p1f, input bit p2r, input bit p2f,
                                     input bit halted);
    return {25'd0, phi1, phi2, p1r, p1f, p2r, p2f, halted};
  endfunction

  function automatic logic [31:0] obs_vec(input bit b);
    if (b) return mk(b_if.phi1, b_if.phi2, b_if.phase_1_rising, b_if.phase_1_falling,
                     b_if.phase_2_rising, b_if.phase_2_falling, b_if.halted);
    return mk(a_if.phi1, a_if.phi2, a_if.phase_1_rising, a_if.phase_1_falling,
              a_if.phase_2_rising, a_if.phase_2_falling, a_if.halted);
  endfunction

  // Compare every entry that belongs to the edge just taken.
  always @(negedge sys_clock) begin : monitor
    exp_t        e;
    logic [31:0] got;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
      e = exp_q.pop_front();
      if (e.is_count) got = e.dut_b ? 32'(b_if.cycle_count) : 32'(a_if.cycle_count);
      else            got = obs_vec(e.dut_b);
      check(e.tag, got, e.exp);
    end
  end

  task automatic push(input bit b, input bit is_count, input string tag, input logic [31:0] v);
    exp_t e;
    e.cyc      = cyc_n + 1;
    e.tag      = $sformatf("%s%s@%0d", tag, is_count ? "_cnt" : "", cyc_n + 1);
    e.dut_b    = b;
    e.is_count = is_count;
    e.exp      = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  // Nominal A timeline for a given position within the period.
  function automatic logic [31:0] a_vec(input int pos);
    return mk(pos < A_H,
              (pos >= A_H + A_G) && (pos < 2 * A_H + A_G),
              pos == 0, pos == A_H, pos == A_H + A_G, pos == 2 * A_H + A_G, 1'b0);
  endfunction

  task automatic a_run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      a_pos = (a_pos + 1) % A_PER;
      if (a_pos == 2 * A_H + A_G) a_count = (a_count + 1) & 16'hFFFF;
      push(1'b0, 1'b0, tag, a_vec(a_pos));
      push(1'b0, 1'b1, tag, 32'(a_count));
      tick();
    end
  endtask

  task automatic a_hold(input int n, input string tag, input logic [31:0] v);
    for (int i = 0; i < n; i++) begin
      push(1'b0, 1'b0, tag, v);
      push(1'b0, 1'b1, tag, 32'(a_count));
      tick();
    end
  endtask

  // B: phi1 on odd edges, phi2 on even edges after reset release.
  task automatic b_run(input int n, input string tag);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      b_k++;
      if (b_k == 1)          v = mk(1, 0, 1, 0, 0, 0, 0);
      else if (b_k % 2 == 0) v = mk(0, 1, 0, 1, 1, 0, 0);
      else                   v = mk(1, 0, 1, 0, 0, 1, 0);
      push(1'b1, 1'b0, tag, v);
      push(1'b1, 1'b1, tag, 32'(((b_k - 1) / 2) & 8'hFF));
      tick();
    end
  endtask

  initial begin
    a_if.enable = 1'b1; a_if.step = 1'b0; a_if.rdy = 1'b1; a_if.rw = 1'b1;
    b_if.enable = 1'b1; b_if.step = 1'b0; b_if.rdy = 1'b1; b_if.rw = 1'b1;
    reset_a = 1'b1;
    reset_b = 1'b1;
    a_pos = A_PER - 1; a_count = 0; b_k = 0;
    tick();
    tick();

    // Reset state of both instances
    push(1'b0, 1'b0, "a_reset", 32'd0);
    push(1'b0, 1'b1, "a_reset", 32'd0);
    push(1'b1, 1'b0, "b_reset", 32'd0);
    push(1'b1, 1'b1, "b_reset", 32'd0);
    tick();

    // Free run: three full periods, count reaches 3
    reset_a = 1'b0;
    a_run(3 * A_PER, "a_free");

    // RDY low outside the last PHI1 count does nothing, then stalls a read
    a_if.rdy = 1'b0;
    a_run(4, "a_rdy_early");
    a_hold(7, "a_stall", mk(1, 0, 0, 0, 0, 0, 0));
    a_if.rdy = 1'b1;
    a_run(A_PER, "a_resume");

    // Writes ignore RDY
    a_if.rw  = 1'b0;
    a_if.rdy = 1'b0;
    a_run(A_PER, "a_write");
    a_if.rw  = 1'b1;
    a_if.rdy = 1'b1;

    // Halt requested mid-PHI2: cycle completes, then HALT
    a_run(3, "a_pre_halt");
    a_if.enable = 1'b0;
    a_run(3, "a_finish");
    a_hold(3, "a_halt", mk(0, 0, 0, 0, 0, 0, 1));

    // One step pulse in HALT runs exactly one cycle
    a_pos = A_PER - 1;
    a_if.step = 1'b1;
    a_run(1, "a_step");
    a_if.step = 1'b0;
    a_run(A_PER - 1, "a_step_cyc");
    a_hold(2, "a_halt2", mk(0, 0, 0, 0, 0, 0, 1));

    // Two pulses during a stepped cycle grant a single extra cycle
    a_pos = A_PER - 1;
    a_if.step = 1'b1; a_run(1, "a_step2");
    a_if.step = 1'b0; a_run(2, "a_step2");
    a_if.step = 1'b1; a_run(1, "a_step2_lat");
    a_if.step = 1'b0; a_run(2, "a_step2");
    a_if.step = 1'b1; a_run(1, "a_step2_lat");
    a_if.step = 1'b0; a_run(3, "a_step2");
    a_run(A_PER, "a_extra");
    a_hold(2, "a_halt3", mk(0, 0, 0, 0, 0, 0, 1));

    // Resume, then reset just before phase_2_rising would fire
    a_pos = A_PER - 1;
    a_if.enable = 1'b1;
    a_run(A_H + A_G, "a_run2");
    reset_a = 1'b1;
    a_count = 0;
    push(1'b0, 1'b0, "a_mid_reset", 32'd0);
    push(1'b0, 1'b1, "a_mid_reset", 32'd0);
    tick();
    reset_a = 1'b0;
    a_pos = A_PER - 1;
    a_run(12, "a_after_reset");

    // B: alternating phases and counter wrap 0xFF -> 0x00
    reset_b = 1'b0;
    b_k = 0;
    b_run(513, "b_wrap");

    // B: reset while in PHI2 with the counter at 0xFF
    reset_b = 1'b1;
    push(1'b1, 1'b0, "b_reset2", 32'd0);
    tick();
    reset_b = 1'b0;
    b_k = 0;
    b_run(512, "b_to_ff");
    reset_b = 1'b1;
    push(1'b1, 1'b0, "b_reset_ff", 32'd0);
    push(1'b1, 1'b1, "b_reset_ff", 32'd0);
    tick();
    reset_b = 1'b0;
    b_k = 0;
    b_run(4, "b_restart");

    @(negedge sys_clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_generator.md
Name: phase_generator

Overview:
- Generates the two-phase, non-overlapping CPU clocks (phi1/phi2) from sys_clock.
- Emits one-sys_clock-wide edge strobes: phase_1_rising, phase_2_rising, phase_1_falling, phase_2_falling.
- These strobes feed the program counter and every other datapath register that commits on phase 2.
- Implements RDY stalling of read cycles, run/halt control and single-step for debug.

Parameters:
- HALF_PERIOD, 4: sys_clock cycles phi1 (and phi2) is held high; legal range 1..255.
- GAP_CYCLES, 1: sys_clock cycles with both phases low between phases; legal range 0..15.
- COUNT_WIDTH, 16: width of cycle_count.

Ports:
- sys_clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- enable  input  1  1 = free-run; 0 = halt at next cycle boundary
- step  input  1  single-cycle pulse; while halted, runs exactly one CPU cycle
- rdy  input  1  6502 RDY; 0 stalls read cycles
- rw  input  1  1 = current CPU cycle is a read, 0 = write
- phi1  output  1  phase 1 clock level
- phi2  output  1  phase 2 clock level
- phase_1_rising  output  1  high on the first sys_clock cycle phi1 reads 1
- phase_1_falling  output  1  high on the first sys_clock cycle phi1 reads 0 after being 1
- phase_2_rising  output  1  high on the first sys_clock cycle phi2 reads 1
- phase_2_falling  output  1  high on the first sys_clock cycle phi2 reads 0 after being 1
- halted  output  1  1 while parked in HALT
- cycle_count  output  COUNT_WIDTH  completed CPU cycles; wraps modulo 2^COUNT_WIDTH

Behaviour:
- All outputs are registered. States: HALT, PHI1, GAP12, PHI2, GAP21. The counter cnt spans 8 bits and resets to 0 on every state entry.
- Reset:
  - state=PHI1, cnt=0, all outputs 0, cycle_count=0.
  - On the first clock after reset deasserts: phi1=1 and phase_1_rising=1.
  - Reset asserted mid-phase overrides everything on the next edge, including strobes.
- PHI1:
  - phi1=1.
  - Exit at cnt==HALF_PERIOD-1.
  - Stall: if rdy==0 and rw==1 at that cnt, remain in PHI1 with phi1 held high and cnt frozen. No strobes while stalled. Exit on the first cycle rdy==1.
  - Writes (rw==0) ignore rdy.
- GAP12 / GAP21:
  - Both phases 0 for GAP_CYCLES cycles.
  - When GAP_CYCLES==0 these states are skipped. phi1 and phi2 then switch on the same edge, and the falling and rising strobes fire on that same cycle.
- PHI2:
  - phi2=1 for HALF_PERIOD cycles.
  - phase_2_rising fires on entry.
  - cycle_count increments on the edge that leaves PHI2.
- Cycle boundary: the transition out of GAP21 (or out of PHI2 when GAP_CYCLES==0).
  - If enable==1, or a step was latched, go to PHI1 with phase_1_rising.
  - Otherwise go to HALT.
- HALT:
  - phi1=phi2=0, halted=1.
  - Leave to PHI1 when enable==1 or step==1.
  - step is latched: a step pulse during a running cycle while enable==0 grants one additional cycle. Multiple pulses within one cycle count as one.
- Simultaneous events:
  - reset beats everything.
  - enable going low mid-cycle completes the current cycle.
  - rdy toggling outside the last PHI1 count has no effect.
- Nominal period = 2*(HALF_PERIOD+GAP_CYCLES) sys_clocks.
- phi1 and phi2 are never both 1 (asserted invariant).

Decomposition:
- Package phase_pkg holds:
  - the state enum (HALT, PHI1, GAP12, PHI2, GAP21);
  - a CNT_WIDTH=8 localparam;
  - a compile-time check function validating HALF_PERIOD/GAP_CYCLES ranges.
- No sub-module. Edge strobes derive from next-state decode inside the block, not from a separate edge detector, so strobes coincide exactly with level changes.

Test Plan:
- Defaults, enable=1, rdy=1, release reset at t0 -> phi1 high cycles t0+1..t0+4, gap t0+5, phi2 high t0+6..t0+9, gap t0+10. Period 10. One of each strobe per period. cycle_count=3 after 30 cycles.
- rw=1, rdy=0 held for 7 cycles starting at last PHI1 count -> phi1 stays high 7 extra cycles, no phase_2_rising in that window. Resumes with phase_2_rising 1 cycle (GAP) after rdy=1.
- rw=0, rdy=0 -> no stall. Timing identical to scenario 1.
- enable=0 mid-PHI2 -> cycle completes, then halted=1 and phi1=phi2=0. A step pulse -> exactly one cycle (one phase_2_rising, cycle_count +1), then halted=1 again.
- GAP_CYCLES=0, HALF_PERIOD=1 -> phi1/phi2 alternate every sys_clock. phase_1_falling and phase_2_rising are asserted in the same cycle. Never both phases high.
- Reset asserted during PHI2 with cycle_count=0xFFFF -> next edge all outputs 0, cycle_count=0. A separate run from 0xFFFF verifies wrap to 0x0000.
